// File: rtl/simple_clock_12_24.sv
// Time-of-day counter (24 h or 12 h view) with button time-setting, sibling sync and 7-segment output.
// Latency: state updates on the clk edge after an input pulse; displays are combinational from registers.
module simple_clock_12_24 #(
   parameter int FORMAT = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       active,
   input  logic       real_clk,
   input  logic       real_quarter,
   input  logic       pulsed_set,
   input  logic       pulsed_up,
   input  logic       pulsed_down,
   input  logic       sync_in_valid,
   input  logic       sync_in_pm,
   input  logic [4:0] sync_in_hours,
   input  logic [5:0] sync_in_minutes,
   output logic [6:0] disp0,
   output logic [6:0] disp1,
   output logic [6:0] disp2,
   output logic [6:0] disp3,
   output logic [6:0] disp4,
   output logic [6:0] disp5,
   output logic [1:0] state,
   output logic       sync_out_valid,
   output logic       sync_out_pm,
   output logic [4:0] sync_out_hours,
   output logic [5:0] sync_out_minutes,
   output logic [4:0] cur_hours24,
   output logic [5:0] cur_minutes
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [4:0] h_q, h_d;
   logic [5:0] m_q, m_d;
   logic [5:0] s_q, s_d;
   logic       sov_q, sov_d;

   logic       up_only, down_only;
   logic [4:0] sync_h;
   logic [4:0] h_mod12, hour12;

   assign up_only   = pulsed_up & ~pulsed_down;
   assign down_only = pulsed_down & ~pulsed_up;

   // The sibling always speaks the other format, so decode from its view.
   always_comb begin
      sync_h = sync_in_hours;
      if (FORMAT == 24) begin
         sync_h = 5'(sync_in_hours % 5'd12) + (sync_in_pm ? 5'd12 : 5'd0);
      end
   end

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      m_d     = m_q;
      s_d     = s_q;
      sov_d   = 1'b0;
      if (sync_in_valid) begin
         h_d     = sync_h;
         m_d     = sync_in_minutes;
         s_d     = 6'd0;
         state_d = ST_RUN;
      end else if (active && pulsed_set) begin
         case (state_q)
            ST_RUN:      state_d = ST_SET_HOUR;
            ST_SET_HOUR: state_d = ST_SET_MIN;
            default: begin
               state_d = ST_RUN;
               s_d     = 6'd0;
               sov_d   = 1'b1;
            end
         endcase
      end else if (state_q == ST_RUN || !active) begin
         state_d = ST_RUN;
         if (state_q == ST_RUN && real_clk) begin
            if (s_q == 6'd59) begin
               s_d = 6'd0;
               if (m_q == 6'd59) begin
                  m_d = 6'd0;
                  h_d = (h_q == 5'd23) ? 5'd0 : h_q + 5'd1;
               end else begin
                  m_d = m_q + 6'd1;
               end
            end else begin
               s_d = s_q + 6'd1;
            end
         end
      end else if (state_q == ST_SET_HOUR) begin
         if (up_only)   h_d = (h_q == 5'd23) ? 5'd0 : h_q + 5'd1;
         if (down_only) h_d = (h_q == 5'd0) ? 5'd23 : h_q - 5'd1;
      end else begin
         if (up_only)   m_d = (m_q == 6'd59) ? 6'd0 : m_q + 6'd1;
         if (down_only) m_d = (m_q == 6'd0) ? 6'd59 : m_q - 6'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         h_q     <= 5'd0;
         m_q     <= 6'd0;
         s_q     <= 6'd0;
         sov_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         m_q     <= m_d;
         s_q     <= s_d;
         sov_q   <= sov_d;
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1111110;
         4'd1:    seg7 = 7'b0110000;
         4'd2:    seg7 = 7'b1101101;
         4'd3:    seg7 = 7'b1111001;
         4'd4:    seg7 = 7'b0110011;
         4'd5:    seg7 = 7'b1011011;
         4'd6:    seg7 = 7'b1011111;
         4'd7:    seg7 = 7'b1110000;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1111011;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_P     = 7'b1100111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   assign h_mod12 = (h_q >= 5'd12) ? h_q - 5'd12 : h_q;
   assign hour12  = (h_mod12 == 5'd0) ? 5'd12 : h_mod12;

   logic [4:0] disp_h;
   logic       hr_vis, min_vis;

   assign disp_h  = (FORMAT == 12) ? hour12 : h_q;
   assign hr_vis  = !(state_q == ST_SET_HOUR && !real_quarter);
   assign min_vis = !(state_q == ST_SET_MIN && !real_quarter);

   always_comb begin
      disp0 = hr_vis ? seg7(4'(disp_h / 5'd10)) : SEG_BLANK;
      disp1 = hr_vis ? seg7(4'(disp_h % 5'd10)) : SEG_BLANK;
      disp2 = min_vis ? seg7(4'(m_q / 6'd10)) : SEG_BLANK;
      disp3 = min_vis ? seg7(4'(m_q % 6'd10)) : SEG_BLANK;
      disp4 = seg7(4'(s_q / 6'd10));
      disp5 = seg7(4'(s_q % 6'd10));
      if (FORMAT == 12) begin
         disp4 = (h_q >= 5'd12) ? SEG_P : SEG_A;
         disp5 = SEG_BLANK;
      end
   end

   assign state            = state_q;
   assign sync_out_valid   = sov_q;
   assign sync_out_pm      = (h_q >= 5'd12);
   assign sync_out_hours   = disp_h;
   assign sync_out_minutes = m_q;
   assign cur_hours24      = h_q;
   assign cur_minutes      = m_q;

endmodule

// File: tb/tb_simple_clock_12_24.sv
// Directed bench: a 24 h and a 12 h instance sharing buttons and ticks, each with its own sync input.
module tb_simple_clock_12_24;

   logic clk, reset, active, real_clk, real_quarter;
   logic pulsed_set, pulsed_up, pulsed_down;
   logic s24_vld, s24_pm, s12_vld, s12_pm;
   logic [4:0] s24_h, s12_h;
   logic [5:0] s24_m, s12_m;

   logic [6:0] a0, a1, a2, a3, a4, a5;
   logic [6:0] b0, b1, b2, b3, b4, b5;
   logic [1:0] a_st, b_st;
   logic       a_sov, b_sov, a_pm, b_pm;
   logic [4:0] a_sh, b_sh, a_h, b_h;
   logic [5:0] a_sm, b_sm, a_m, b_m;

   int checks = 0;
   int errors = 0;

   simple_clock_12_24 #(.FORMAT(24)) u24 (
      .clk(clk), .reset(reset), .active(active), .real_clk(real_clk),
      .real_quarter(real_quarter), .pulsed_set(pulsed_set), .pulsed_up(pulsed_up),
      .pulsed_down(pulsed_down), .sync_in_valid(s24_vld), .sync_in_pm(s24_pm),
      .sync_in_hours(s24_h), .sync_in_minutes(s24_m),
      .disp0(a0), .disp1(a1), .disp2(a2), .disp3(a3), .disp4(a4), .disp5(a5),
      .state(a_st), .sync_out_valid(a_sov), .sync_out_pm(a_pm), .sync_out_hours(a_sh),
      .sync_out_minutes(a_sm), .cur_hours24(a_h), .cur_minutes(a_m)
   );

   simple_clock_12_24 #(.FORMAT(12)) u12 (
      .clk(clk), .reset(reset), .active(active), .real_clk(real_clk),
      .real_quarter(real_quarter), .pulsed_set(pulsed_set), .pulsed_up(pulsed_up),
      .pulsed_down(pulsed_down), .sync_in_valid(s12_vld), .sync_in_pm(s12_pm),
      .sync_in_hours(s12_h), .sync_in_minutes(s12_m),
      .disp0(b0), .disp1(b1), .disp2(b2), .disp3(b3), .disp4(b4), .disp5(b5),
      .state(b_st), .sync_out_valid(b_sov), .sync_out_pm(b_pm), .sync_out_hours(b_sh),
      .sync_out_minutes(b_sm), .cur_hours24(b_h), .cur_minutes(b_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] seg [10];
   localparam logic [6:0] SA = 7'b1110111;
   localparam logic [6:0] SP = 7'b1100111;
   localparam logic [6:0] SB = 7'b0000000;

   typedef struct {
      logic st, up, dn, tk;
      int   e_state, e_h, e_m;
      logic e_sov;
   } vec_t;
   vec_t vecs [20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs applied at a falling edge, captured on the next rising edge, released one falling edge later.
   task automatic step(input logic st, input logic up, input logic dn, input logic tk);
      pulsed_set  = st;
      pulsed_up   = up;
      pulsed_down = dn;
      real_clk    = tk;
      @(negedge clk);
      pulsed_set  = 1'b0;
      pulsed_up   = 1'b0;
      pulsed_down = 1'b0;
      real_clk    = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic sync_pulse(input logic v24, input logic pm24, input logic [4:0] h24, input logic [5:0] m24,
                             input logic v12, input logic [4:0] h12, input logic [5:0] m12);
      s24_vld = v24; s24_pm = pm24; s24_h = h24; s24_m = m24;
      s12_vld = v12; s12_pm = 1'b0; s12_h = h12; s12_m = m12;
      @(negedge clk);
      s24_vld = 1'b0;
      s12_vld = 1'b0;
   endtask

   initial begin
      seg[0] = 7'b1111110; seg[1] = 7'b0110000; seg[2] = 7'b1101101; seg[3] = 7'b1111001;
      seg[4] = 7'b0110011; seg[5] = 7'b1011011; seg[6] = 7'b1011111; seg[7] = 7'b1110000;
      seg[8] = 7'b1111111; seg[9] = 7'b1111011;

      // Set sequence from 00:00: set, up x13, up+down, tick, set, down, set, idle.
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b0};
      for (int i = 1; i <= 13; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, i, 0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 13, 0, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 13, 0, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 13, 0, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 13, 59, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 13, 59, 1'b1};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 13, 59, 1'b0};

      reset = 1'b1; active = 1'b1; real_clk = 1'b0; real_quarter = 1'b1;
      pulsed_set = 1'b0; pulsed_up = 1'b0; pulsed_down = 1'b0;
      s24_vld = 1'b0; s24_pm = 1'b0; s24_h = '0; s24_m = '0;
      s12_vld = 1'b0; s12_pm = 1'b0; s12_h = '0; s12_m = '0;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", a_st, 0);
      chk("rst_h", a_h, 0);
      chk("rst_m", a_m, 0);
      chk("rst_sov", a_sov, 0);
      chk("rst_disp5", a5, seg[0]);
      reset = 1'b1;
      @(negedge clk);

      ticks(61);
      chk("t61_d0", a0, seg[0]);
      chk("t61_d1", a1, seg[0]);
      chk("t61_d2", a2, seg[0]);
      chk("t61_d3", a3, seg[1]);
      chk("t61_d4", a4, seg[0]);
      chk("t61_d5", a5, seg[1]);
      chk("t61_12_d0", b0, seg[1]);
      chk("t61_12_d1", b1, seg[2]);
      chk("t61_12_d4", b4, SA);
      chk("t61_12_d5", b5, SB);

      // 24 h side gets 11 PM in 12 h form; 12 h side gets 23 in 24 h form.
      sync_pulse(1'b1, 1'b1, 5'd11, 6'd59, 1'b1, 5'd23, 6'd59);
      chk("sync_pre_h24", a_h, 23);
      chk("sync_pre_h12", b_h, 23);
      chk("sync_pre_d5", a5, seg[0]);
      ticks(59);
      chk("235959_d4", a4, seg[5]);
      chk("235959_d5", a5, seg[9]);
      ticks(1);
      chk("wrap_h", a_h, 0);
      chk("wrap_m", a_m, 0);
      chk("wrap_d5", a5, seg[0]);
      chk("wrap_12_d0", b0, seg[1]);
      chk("wrap_12_d1", b1, seg[2]);
      chk("wrap_12_d2", b2, seg[0]);
      chk("wrap_12_d3", b3, seg[0]);
      chk("wrap_12_d4", b4, SA);

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].st, vecs[i].up, vecs[i].dn, vecs[i].tk);
         chk($sformatf("vec%0d_state", i), a_st, vecs[i].e_state);
         chk($sformatf("vec%0d_h", i), a_h, vecs[i].e_h);
         chk($sformatf("vec%0d_m", i), a_m, vecs[i].e_m);
         chk($sformatf("vec%0d_sov", i), a_sov, vecs[i].e_sov);
         chk($sformatf("vec%0d_12_state", i), b_st, vecs[i].e_state);
         chk($sformatf("vec%0d_12_sov", i), b_sov, vecs[i].e_sov);
      end
      chk("so24_hours", a_sh, 13);
      chk("so24_pm", a_pm, 1);
      chk("so12_hours", b_sh, 1);
      chk("so12_pm", b_pm, 1);
      chk("so12_min", b_sm, 59);

      step(1'b1, 1'b0, 1'b0, 1'b0);
      real_quarter = 1'b0;
      #1;
      chk("blinkh_d0", a0, SB);
      chk("blinkh_d1", a1, SB);
      chk("blinkh_d2", a2, seg[5]);
      chk("blinkh_d3", a3, seg[9]);
      chk("blinkh_d4", a4, seg[0]);
      chk("blinkh_d5", a5, seg[0]);
      chk("blinkh_12_d0", b0, SB);
      chk("blinkh_12_d4", b4, SP);
      @(negedge clk);
      ticks(2);
      chk("sethr_tick_h", a_h, 13);
      chk("sethr_tick_m", a_m, 59);
      chk("sethr_tick_d5", a5, seg[0]);
      real_quarter = 1'b1;
      #1;
      chk("showh_d0", a0, seg[1]);
      chk("showh_d1", a1, seg[3]);
      chk("showh_12_d1", b1, seg[1]);
      @(negedge clk);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      real_quarter = 1'b0;
      #1;
      chk("blinkm_state", a_st, 2);
      chk("blinkm_d0", a0, seg[1]);
      chk("blinkm_d2", a2, SB);
      chk("blinkm_d3", a3, SB);

      // Asynchronous reset between clock edges while setting minutes.
      #1 reset = 1'b0;
      #1;
      chk("arst_state", a_st, 0);
      chk("arst_h", a_h, 0);
      chk("arst_m", a_m, 0);
      chk("arst_12_h", b_h, 0);
      real_quarter = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      ticks(3);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("pre_sync_state", a_st, 1);
      sync_pulse(1'b1, 1'b1, 5'd12, 6'd5, 1'b1, 5'd7, 6'd30);
      chk("syncpm_state", a_st, 0);
      chk("syncpm_h", a_h, 12);
      chk("syncpm_m", a_m, 5);
      chk("syncpm_d4", a4, seg[0]);
      chk("syncpm_d5", a5, seg[0]);
      chk("sync12_h", b_h, 7);
      chk("sync12_m", b_m, 30);
      chk("sync12_d0", b0, seg[0]);
      chk("sync12_d1", b1, seg[7]);
      chk("sync12_d2", b2, seg[3]);
      chk("sync12_d4", b4, SA);
      sync_pulse(1'b1, 1'b0, 5'd12, 6'd5, 1'b0, 5'd0, 6'd0);
      chk("syncam_h", a_h, 0);
      chk("syncam_m", a_m, 5);
      chk("syncam_12_h", b_h, 7);

      active = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("inact_state", a_st, 0);
      chk("inact_d5", a5, seg[1]);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("inact_up_h", a_h, 0);
      chk("inact_up_m", a_m, 5);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("inact_state2", a_st, 0);
      chk("inact_12_state", b_st, 0);
      chk("inact_12_h", b_h, 7);
      chk("inact_12_m", b_m, 30);
      active = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/simple_clock_12_24.md
Name: simple_clock_12_24

Overview:
- Parameterised time-of-day counter with button-driven time setting and seven-segment display encoding.
- FORMAT=24 covers the SimpleClock24 role; FORMAT=12 covers the SimpleClock12 role (12 h with AM/PM).
- Two instances (one per format) run side by side under a display wrapper.
- After a time-set, each instance pushes the new time to its sibling so both stay in sync.

Parameters:
FORMAT, 24, display/sync format: 24 or 12.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  asynchronous, active-low; 0 clears all state.
active  in  1  1 = this instance owns the buttons. When 0, set/up/down are ignored.
real_clk  in  1  one-clk-wide 1 Hz tick, synchronous to clk.
real_quarter  in  1  blink phase level (1 = visible).
pulsed_set  in  1  one-clk pulse from the set button.
pulsed_up  in  1  one-clk pulse from the up button.
pulsed_down  in  1  one-clk pulse from the down button.
sync_in_valid  in  1  one-clk pulse: load time from the sibling instance.
sync_in_pm  in  1  sibling PM flag. Used only when FORMAT=24.
sync_in_hours  in  5  sibling hours, in the sibling's format.
sync_in_minutes  in  6  sibling minutes, 0-59.
disp0..disp5  out  7 each  segments {a,b,c,d,e,f,g}, active-high.
state  out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN.
sync_out_valid  out  1  one-clk pulse when a set sequence completes.
sync_out_pm  out  1  1 when the hour is 12-23.
sync_out_hours  out  5  FORMAT=24: 0-23. FORMAT=12: 1-12.
sync_out_minutes  out  6  current minutes.
cur_hours24  out  5  current hour, always 0-23.
cur_minutes  out  6  current minutes.

Behaviour:
Internal time representation:
- Registers h (0-23), m, s. The 12 h view is derived from h.
  - hour12 = 12 when h mod 12 == 0, else h mod 12.
  - pm = (h >= 12).

Reset (reset=0, asynchronous):
- h = m = s = 0, state = RUN, sync_out_valid = 0.

RUN, on real_clk:
- s increments; 59 wraps to 0 and increments m.
- m 59 wraps to 0 and increments h.
- h 23 wraps to 0, i.e. 23:59:59 -> 00:00:00.

State transitions (only when active=1, on pulsed_set):
- RUN -> SET_HOUR -> SET_MIN -> RUN.
- On the SET_MIN -> RUN edge: s := 0, and sync_out_valid = 1 for exactly the next clk cycle. sync_out_* carry the new time.

Setting fields:
- Time does not advance while state != RUN; real_clk is ignored.
- SET_HOUR: up does h+1 mod 24, down does h-1 mod 24.
  - In FORMAT=12 this walks 11 PM -> 12 AM -> 1 AM.
- SET_MIN: up/down change m mod 60. h does not carry.

Priorities and ignored inputs:
- pulsed_set takes priority over up/down in the same cycle.
- up and down together: both ignored.
- When active=0: state is forced to RUN and the buttons are ignored.

Sync input (any state, on sync_in_valid):
- Load h and m, set s := 0, state := RUN.
- Higher priority than buttons and real_clk.
- FORMAT=24 decodes 12 h input:
  - h = (sync_in_hours mod 12) + (sync_in_pm ? 12 : 0).
- FORMAT=12 decodes 24 h input: h = sync_in_hours; sync_in_pm is ignored.

Display, combinational from registers:
- Digit codes:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - A = 1110111, P = 1100111, blank = 0000000
- FORMAT=24:
  - disp0/1 = h tens/ones.
  - disp2/3 = m tens/ones.
  - disp4/5 = s tens/ones, so disp5 = 1111110 exactly when the s ones digit is 0.
- FORMAT=12:
  - disp0/1 = hour12 tens/ones, 01-12.
  - disp2/3 = minutes.
  - disp4 = A or P.
  - disp5 = blank.

Blinking while setting:
- In SET_HOUR, disp0/1 are blank while real_quarter = 0.
- In SET_MIN, disp2/3 are blank while real_quarter = 0.
- All other digits are unaffected.

Other outputs:
- cur_hours24 / cur_minutes always equal h / m.

Test Plan:
- Reset, then 61 real_clk ticks -> FORMAT=24 display 00:01:01. disp5 = 0110000, disp4 = 1111110.
- Preload 23:59:59 via sync, then one tick -> 00:00:00; FORMAT=12 shows 12, A, 00.
- set, up x13, set, down x1, set -> state sequence 1, 2, 0.
  - Time 13:59:00; sync_out_valid high for one cycle.
  - FORMAT=24 sync_out_hours = 13; FORMAT=12 sync_out_hours = 1 with pm = 1.
- In SET_HOUR with real_quarter = 0 -> disp0/1 = 0000000 and disp2..5 unchanged. Ticks do not advance time.
- FORMAT=24 receives sync_in pm=1, hours=12, minutes=5 -> h = 12, m = 5, s = 0.
  - Same with pm=0, hours=12 -> h = 0.
- active=0 with set/up pulses -> state stays 0 and time is unchanged apart from normal ticks.
- Assert reset mid-SET_MIN -> immediate 00:00:00, state 0.
